// File: rtl/i2c_master_controller.sv
// I2C register-access master: one-byte register write or read per request.
// Bit time is four quarters of CLK_DIV clocks; SCL is low in Q0/Q1.
`timescale 1ns/1ps
module i2c_master_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_SEND_BYTE,
    S_GET_ACK,
    S_RSTART,
    S_READ_BYTE,
    S_SEND_NACK,
    S_STOP,
    S_DONE
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(CLK_DIV - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_cnt;
  logic [1:0] r_q;
  logic [2:0] r_bit;
  logic [1:0] r_phase;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic [7:0] r_rdata;
  logic       r_nack;
  logic       r_rw;
  logic [6:0] r_dev;
  logic [7:0] r_reg;
  logic [7:0] r_wdata;
  logic       w_qend;
  logic       w_bend;
  logic       w_smp;

  assign w_qend = (r_cnt == LP_LAST);
  assign w_bend = w_qend && (r_q == 2'd3);
  assign w_smp  = w_qend && (r_q == 2'd2);
  assign rdata  = r_rdata;

  always_comb begin
    w_next  = r_state;
    sda_oe  = 1'b0;
    scl_oe  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    ack_err = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_START;
      end
      S_START, S_RSTART: begin
        scl_oe = ~r_q[1];
        sda_oe = r_q[1];
        busy   = 1'b1;
        if (w_bend) w_next = S_SEND_BYTE;
      end
      S_SEND_BYTE: begin
        scl_oe = ~r_q[1];
        sda_oe = ~r_tx[7];
        busy   = 1'b1;
        if (w_bend && r_bit == 3'd7) w_next = S_GET_ACK;
      end
      S_GET_ACK: begin
        scl_oe = ~r_q[1];
        busy   = 1'b1;
        if (w_bend) begin
          if (r_nack) w_next = S_STOP;
          else if (r_phase == 2'd0) w_next = S_SEND_BYTE;
          else if (r_phase == 2'd1) w_next = r_rw ? S_RSTART : S_SEND_BYTE;
          else w_next = r_rw ? S_READ_BYTE : S_STOP;
        end
      end
      S_READ_BYTE: begin
        scl_oe = ~r_q[1];
        busy   = 1'b1;
        if (w_bend && r_bit == 3'd7) w_next = S_SEND_NACK;
      end
      S_SEND_NACK: begin
        scl_oe = ~r_q[1];
        busy   = 1'b1;
        if (w_bend) w_next = S_STOP;
      end
      S_STOP: begin
        scl_oe = ~r_q[1];
        sda_oe = (r_q != 2'd3);
        busy   = 1'b1;
        if (w_bend) w_next = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        ack_err = r_nack;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_q     <= 2'd0;
      r_bit   <= 3'd0;
      r_phase <= 2'd0;
      r_tx    <= 8'd0;
      r_rx    <= 8'd0;
      r_rdata <= 8'd0;
      r_nack  <= 1'b0;
      r_rw    <= 1'b0;
      r_dev   <= 7'd0;
      r_reg   <= 8'd0;
      r_wdata <= 8'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE || r_state == S_DONE) begin
        r_cnt <= 8'd0;
        r_q   <= 2'd0;
        r_bit <= 3'd0;
      end else begin
        r_cnt <= w_qend ? 8'd0 : r_cnt + 8'd1;
        if (w_qend) r_q <= r_q + 2'd1;
        if (w_bend && (r_state == S_SEND_BYTE ||
                       r_state == S_READ_BYTE))
          r_bit <= r_bit + 3'd1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rw    <= rw;
            r_dev   <= dev_addr;
            r_reg   <= reg_addr;
            r_wdata <= wdata;
            r_nack  <= 1'b0;
            r_phase <= 2'd0;
          end
        end
        S_START: begin
          if (w_bend) begin
            r_tx    <= {r_dev, 1'b0};
            r_phase <= 2'd0;
          end
        end
        S_RSTART: begin
          if (w_bend) begin
            r_tx    <= {r_dev, 1'b1};
            r_phase <= 2'd2;
          end
        end
        S_SEND_BYTE: begin
          if (w_bend) r_tx <= {r_tx[6:0], 1'b0};
        end
        S_GET_ACK: begin
          if (w_smp) r_nack <= sda_in;
          // Next byte is loaded only when the slave acknowledged.
          if (w_bend && !r_nack) begin
            if (r_phase == 2'd0) begin
              r_tx    <= r_reg;
              r_phase <= 2'd1;
            end else if (r_phase == 2'd1 && !r_rw) begin
              r_tx    <= r_wdata;
              r_phase <= 2'd2;
            end
          end
        end
        S_READ_BYTE: begin
          if (w_smp) r_rx <= {r_rx[6:0], sda_in};
          if (w_bend && r_bit == 3'd7) r_rdata <= r_rx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_controller.sv
// Bench for i2c_master_controller: bit-slot waveform model and slave.
// Two instances cover CLK_DIV=4 and CLK_DIV=1.
`timescale 1ns/1ps
module tb_i2c_master_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, start_b;
  logic       rw;
  logic [6:0] dev;
  logic [7:0] ra, wd;
  logic       pull_a = 1'b0, pull_b = 1'b0;
  logic       sdi_a, sdi_b;
  logic       sda_a, scl_a, busy_a, done_a, aerr_a;
  logic       sda_b, scl_b, busy_b, done_b, aerr_b;
  logic [7:0] rd_a, rd_b;

  assign sdi_a = ~(sda_a | pull_a);
  assign sdi_b = ~(sda_b | pull_b);

  i2c_master_controller #(.CLK_DIV(4)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .rw(rw),
    .dev_addr(dev), .reg_addr(ra), .wdata(wd),
    .sda_in(sdi_a), .sda_oe(sda_a), .scl_oe(scl_a),
    .rdata(rd_a), .busy(busy_a), .done(done_a),
    .ack_err(aerr_a));

  i2c_master_controller #(.CLK_DIV(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .rw(rw),
    .dev_addr(dev), .reg_addr(ra), .wdata(wd),
    .sda_in(sdi_b), .sda_oe(sda_b), .scl_oe(scl_b),
    .rdata(rd_b), .busy(busy_b), .done(done_b),
    .ack_err(aerr_b));

  typedef enum int {K_START, K_TX, K_ACK, K_RX, K_NACK, K_STOP} kind_t;
  typedef struct packed {
    logic scl, sda, busy, done, aerr, pull, stop, rdchk;
    logic [7:0] rd;
  } ent_t;

  ent_t qa[$], qb[$], tq[$];
  bit   mon_a[$], mon_b[$];
  logic [7:0] mrd [2];
  logic prev_scl [2];
  logic prev_sda [2];
  int   vectors = 0;
  int   errors = 0;
  bit   chk_en = 0;

  // One bit slot of expected per-cycle bus behaviour plus slave drive.
  task automatic put_bit(input int D, input kind_t k, input logic v);
    ent_t e;
    for (int q = 0; q < 4; q++) begin
      for (int c = 0; c < D; c++) begin
        e = '0;
        e.scl  = (q < 2);
        e.busy = 1'b1;
        case (k)
          K_START: e.sda = (q >= 2);
          K_TX:    e.sda = ~v;
          K_STOP:  begin e.sda = (q < 3); e.stop = 1'b1; end
          default: e.sda = 1'b0;
        endcase
        e.pull = (k == K_ACK || k == K_RX) ? ~v : 1'b0;
        tq.push_back(e);
      end
    end
  endtask

  task automatic put_byte(input int D, input kind_t k, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) put_bit(D, k, b[i]);
  endtask

  task automatic build(input int D, input int d, input logic rwv,
                       input logic [6:0] dv, input logic [7:0] rav,
                       input logic [7:0] wdv, input logic [7:0] sdv,
                       input logic [2:0] nk);
    ent_t e;
    logic nack;
    tq.delete();
    e = '0; e.rdchk = 1'b1; e.rd = mrd[d];
    tq.push_back(e);
    put_bit(D, K_START, 1'b0);
    put_byte(D, K_TX, {dv, 1'b0});
    put_bit(D, K_ACK, nk[0]);
    nack = nk[0];
    if (!nack) begin
      put_byte(D, K_TX, rav);
      put_bit(D, K_ACK, nk[1]);
      nack = nk[1];
    end
    if (!nack) begin
      if (!rwv) begin
        put_byte(D, K_TX, wdv);
        put_bit(D, K_ACK, nk[2]);
        nack = nk[2];
      end else begin
        put_bit(D, K_START, 1'b0);
        put_byte(D, K_TX, {dv, 1'b1});
        put_bit(D, K_ACK, nk[2]);
        nack = nk[2];
        if (!nack) begin
          put_byte(D, K_RX, sdv);
          put_bit(D, K_NACK, 1'b0);
          mrd[d] = sdv;
        end
      end
    end
    put_bit(D, K_STOP, 1'b0);
    e = '0; e.done = 1'b1; e.aerr = nack; e.rdchk = 1'b1; e.rd = mrd[d];
    tq.push_back(e);
    foreach (tq[i]) begin
      if (d == 0) qa.push_back(tq[i]);
      else qb.push_back(tq[i]);
    end
  endtask

  function automatic ent_t idle_e(input int d);
    ent_t e;
    e = '0; e.rdchk = 1'b1; e.rd = mrd[d];
    return e;
  endfunction

  task automatic check(input int d, input ent_t e, input logic scl,
                       input logic sda, input logic bsy, input logic dn,
                       input logic ae, input logic [7:0] rdv);
    logic [4:0] got, exp;
    logic line;
    got = {scl, sda, bsy, dn, ae};
    exp = {e.scl, e.sda, e.busy, e.done, e.aerr};
    vectors++;
    if (got !== exp || (e.rdchk && rdv !== e.rd)) begin
      errors++;
      $display("FAIL bus%0d t=%0t scl/sda/busy/done/err got %b exp %b rdata got %h exp %h",
               d, $time, got, exp, rdv, e.rd);
    end
    if (prev_scl[d] === 1'b0 && scl === 1'b0) begin
      vectors++;
      if (sda !== prev_sda[d] && !e.stop) begin
        errors++;
        $display("FAIL sda_stable%0d t=%0t sda_oe got %b exp %b", d, $time, sda, prev_sda[d]);
      end
    end
    line = ~(sda | e.pull);
    if (prev_scl[d] === 1'b1 && scl === 1'b0) begin
      if (d == 0) mon_a.push_back(line);
      else mon_b.push_back(line);
    end
    prev_scl[d] = scl;
    prev_sda[d] = sda;
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (chk_en) begin
      e = (qa.size() > 0) ? qa.pop_front() : idle_e(0);
      pull_a = e.pull;
      check(0, e, scl_a, sda_a, busy_a, done_a, aerr_a, rd_a);
      e = (qb.size() > 0) ? qb.pop_front() : idle_e(1);
      pull_b = e.pull;
      check(1, e, scl_b, sda_b, busy_b, done_b, aerr_b, rd_b);
    end
  end

  task automatic lit(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] mbyte(input int d, input int i);
    logic [7:0] b;
    b = 8'h00;
    for (int j = 0; j < 8; j++) begin
      if (d == 0) b = {b[6:0], (i + j < mon_a.size()) ? mon_a[i + j] : 1'b0};
      else b = {b[6:0], (i + j < mon_b.size()) ? mon_b[i + j] : 1'b0};
    end
    return b;
  endfunction

  task automatic set_start(input int d, input logic v);
    if (d == 0) start_a = v;
    else start_b = v;
  endtask

  task automatic txn(input int d, input logic rwv, input logic [6:0] dv,
                     input logic [7:0] rav, input logic [7:0] wdv,
                     input logic [7:0] sdv, input logic [2:0] nk,
                     input int hold, input int rp,
                     output int lat, output logic ae);
    bit seen;
    rw = rwv; dev = dv; ra = rav; wd = wdv;
    if (d == 0) mon_a.delete();
    else mon_b.delete();
    build((d == 0) ? 4 : 1, d, rwv, dv, rav, wdv, sdv, nk);
    set_start(d, 1'b1);
    lat = 0; seen = 0; ae = 1'b0;
    while (!seen && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
      set_start(d, (lat < hold) || (lat == rp));
      if (lat == 7) begin
        rw = 1'($urandom); dev = 7'($urandom);
        ra = 8'($urandom); wd = 8'($urandom);
      end
      if ((d == 0) ? done_a : done_b) begin
        seen = 1;
        ae = (d == 0) ? aerr_a : aerr_b;
      end
    end
    set_start(d, 1'b0);
    vectors++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout%0d got no done exp done within 3000 cycles", d);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    logic ae;
    logic [2:0] nk;
    rst = 1'b1; start_a = 1'b1; start_b = 1'b1;
    rw = 1'b0; dev = 7'h0; ra = 8'h0; wd = 8'h0;
    mrd[0] = 8'h00; mrd[1] = 8'h00;
    prev_scl[0] = 1'b0; prev_scl[1] = 1'b0;
    prev_sda[0] = 1'b0; prev_sda[1] = 1'b0;
    @(posedge clk); #1;
    chk_en = 1;
    repeat (3) @(posedge clk);
    #1;
    lit("reset_rdata", int'(rd_a), 8'h00);
    lit("reset_busy", int'(busy_a), 0);
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0;

    txn(0, 1'b0, 7'h2A, 8'h03, 8'hA5, 8'h00, 3'b000, 1, 0, lat, ae);
    lit("wr_latency", lat, 465);
    lit("wr_bits", mon_a.size(), 29);
    lit("wr_byte0", int'(mbyte(0, 1)), 8'h54);
    lit("wr_byte1", int'(mbyte(0, 10)), 8'h03);
    lit("wr_byte2", int'(mbyte(0, 19)), 8'hA5);
    lit("wr_ackerr", int'(ae), 0);

    txn(0, 1'b1, 7'h2A, 8'h05, 8'h00, 8'h3C, 3'b000, 1, 0, lat, ae);
    lit("rd_latency", lat, 625);
    lit("rd_byte0", int'(mbyte(0, 1)), 8'h54);
    lit("rd_byte1", int'(mbyte(0, 10)), 8'h05);
    lit("rd_byte2", int'(mbyte(0, 20)), 8'h55);
    lit("rd_data_bus", int'(mbyte(0, 29)), 8'h3C);
    lit("rd_master_nack", int'(mon_a.size() > 37 ? mon_a[37] : 1'b0), 1);
    lit("rd_rdata", int'(rd_a), 8'h3C);
    lit("rd_ackerr", int'(ae), 0);

    txn(0, 1'b0, 7'h2A, 8'h07, 8'h11, 8'h00, 3'b001, 1, 0, lat, ae);
    lit("nack_latency", lat, 177);
    lit("nack_bits", mon_a.size(), 11);
    lit("nack_ackerr", int'(ae), 1);
    lit("nack_rdata", int'(rd_a), 8'h3C);

    txn(0, 1'b0, 7'h31, 8'h44, 8'h99, 8'h00, 3'b000, 3, 40, lat, ae);
    lit("hold_latency", lat, 465);
    txn(0, 1'b1, 7'h12, 8'h34, 8'h00, 8'hC3, 3'b000, 1, 0, lat, ae);
    lit("b2b_rdata", int'(rd_a), 8'hC3);

    rw = 1'b0; dev = 7'h2A; ra = 8'h0F; wd = 8'h5A;
    mon_a.delete();
    build(4, 0, 1'b0, 7'h2A, 8'h0F, 8'h5A, 8'h00, 3'b000);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (16 * 13 + 5) @(posedge clk);
    #1;
    lit("pre_rst_busy", int'(busy_a), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    qa.delete();
    mrd[0] = 8'h00; mrd[1] = 8'h00;
    lit("rst_sda", int'(sda_a), 0);
    lit("rst_scl", int'(scl_a), 0);
    lit("rst_busy", int'(busy_a), 0);
    lit("rst_rdata", int'(rd_a), 0);
    txn(0, 1'b0, 7'h2A, 8'h0F, 8'h5A, 8'h00, 3'b000, 1, 0, lat, ae);
    lit("post_rst_latency", lat, 465);

    txn(1, 1'b0, 7'h50, 8'h00, 8'hFF, 8'h00, 3'b000, 1, 0, lat, ae);
    lit("div1_latency", lat, 117);
    lit("div1_bits", mon_b.size(), 29);
    lit("div1_reg", int'(mbyte(1, 10)), 8'h00);
    lit("div1_data", int'(mbyte(1, 19)), 8'hFF);

    for (int n = 0; n < 35; n++) begin
      nk[0] = ($urandom_range(0, 3) == 0);
      nk[1] = ($urandom_range(0, 3) == 0);
      nk[2] = ($urandom_range(0, 3) == 0);
      txn((n < 20) ? 0 : 1, 1'($urandom), 7'($urandom), 8'($urandom),
          8'($urandom), 8'($urandom), nk, $urandom_range(1, 4), 0, lat, ae);
    end

    repeat (5) @(posedge clk);
    #1;
    lit("queue_a_drained", qa.size(), 0);
    lit("queue_b_drained", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master_controller.md
I2C_MASTER_CONTROLLER -- requirements
Module: i2c_master_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCL quarter-period; legal range 1..255.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  transaction request, sampled only in IDLE.
REQ-005 SHALL have port rw  input  1  0 = register write, 1 = register read; captured with start.
REQ-006 SHALL have port dev_addr  input  7  target I2C address; captured with start.
REQ-007 SHALL have port reg_addr  input  8  register index byte; captured with start.
REQ-008 SHALL have port wdata  input  8  write data byte; captured with start.
REQ-009 SHALL have port sda_in  input  1  sampled bus SDA level.
REQ-010 SHALL have port sda_oe  output  1  1 = pull SDA low, 0 = release (open-drain).
REQ-011 SHALL have port scl_oe  output  1  1 = pull SCL low, 0 = release.
REQ-012 SHALL have port rdata  output  8  last byte read; held until the next read completes.
REQ-013 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-014 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-015 SHALL have port ack_err  output  1  valid with done; 1 = a slave NACK aborted the transfer.

Function
REQ-016 SHALL divide each bit into quarters Q0..Q3 of CLK_DIV cycles: Q0/Q1 SCL low, Q2/Q3 SCL released; SDA changes only at Q0 start; sda_in sampled on the last cycle of Q2.
REQ-017 SHALL use states IDLE, START, SEND_BYTE, GET_ACK, RSTART, READ_BYTE, SEND_NACK, STOP, DONE.
REQ-018 IDLE: sda_oe=0, scl_oe=0, busy=0; start=1 captures inputs and enters START on the next cycle.
REQ-019 START: SDA released for Q0-Q1, then pulled low during Q2-Q3 with SCL released; ends with SCL pulled low.
REQ-020 SEND_BYTE SHALL shift 8 bits MSB first; sda_oe = ~bit.
REQ-021 Write sequence: START, {dev_addr,0}, ACK, reg_addr, ACK, wdata, ACK, STOP.
REQ-022 Read sequence: START, {dev_addr,0}, ACK, reg_addr, ACK, RSTART, {dev_addr,1}, ACK, READ_BYTE, SEND_NACK, STOP.
REQ-023 GET_ACK SHALL release SDA; sampled sda_in=1 sets the internal NACK flag and jumps to STOP.
REQ-024 RSTART SHALL behave as START, including the SDA release with SCL low in Q0-Q1.
REQ-025 READ_BYTE SHALL release SDA and shift sda_in MSB first; rdata updates only after bit 0 is sampled.
REQ-026 SEND_NACK SHALL release SDA for one full bit time.
REQ-027 STOP: SDA low during Q0-Q1, SCL released at Q2, SDA released at Q3; both are released on exit.
REQ-028 DONE lasts one cycle: done=1, ack_err=NACK flag, busy=0; next state IDLE.
REQ-029 start asserted while busy SHALL be ignored; captured inputs SHALL NOT change mid-transaction.
REQ-030 SHALL NOT support clock stretching or arbitration; scl_in does not exist.
REQ-031 The quarter counter SHALL wrap from CLK_DIV-1 to 0; the bit counter SHALL wrap 7 to 0 at byte end.

Reset
REQ-032 rst=1 at any clock edge, including mid-transaction, SHALL force IDLE on that edge: sda_oe=0, scl_oe=0, busy=0, done=0, ack_err=0, rdata=8'h00, and all counters 0.
REQ-033 While rst=1, start SHALL be ignored; the first acceptable start is in the first cycle with rst=0.

Verification
REQ-034 Write, CLK_DIV=4: dev_addr=7'h2A, reg_addr=8'h03, wdata=8'hA5, slave ACKs all -> bus bytes 8'h54, 8'h03, 8'hA5, then STOP; done=1 with ack_err=0 after 1+27+1 bit times + 1 cycle.
REQ-035 Read: dev_addr=7'h2A, reg_addr=8'h05, slave returns 8'h3C -> bus bytes 8'h54, 8'h05, repeated START, 8'h55; master NACKs; rdata=8'h3C, ack_err=0.
REQ-036 Address NACK: slave leaves SDA high on the first ACK -> STOP immediately after the first ACK bit; done=1, ack_err=1; rdata unchanged.
REQ-037 rst pulse during the 4th bit of reg_addr -> the next cycle has sda_oe=0, scl_oe=0, busy=0; a new start is accepted one cycle after rst falls.
REQ-038 start held high for 3 cycles and re-pulsed while busy -> exactly one transaction and one done pulse; a second start in the cycle after done starts a new transaction.
REQ-039 CLK_DIV=1 write of 8'hFF to reg 8'h00 -> a correct bus waveform with SCL period of 4 clk cycles; the bench checks that SDA never changes while SCL is released, except during START/STOP.
